// File: rtl/cpu_pkg.sv
// Definitions shared between the CPU decoder and the data memory:
// memory FSM encoding, default access latency and load/store opcodes.
package cpu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_MEM_LATENCY = 5;

    // Opcodes of the load/store instructions, kept here so decoder and memory agree.
    localparam logic [7:0] OP_LWD = 8'h08;
    localparam logic [7:0] OP_LWI = 8'h09;
    localparam logic [7:0] OP_SWD = 8'h0A;
    localparam logic [7:0] OP_SWI = 8'h0B;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_t;

    function automatic logic is_store_op(input logic [7:0] opcode);
        return (opcode == OP_SWD) || (opcode == OP_SWI);
    endfunction

    function automatic logic is_load_op(input logic [7:0] opcode);
        return (opcode == OP_LWD) || (opcode == OP_LWI);
    endfunction

endpackage

// File: rtl/data_memory_dmem_array.sv
// Byte storage for data_memory: every byte cleared on reset, synchronous write,
// and a read register that only updates when a read is enabled.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

    // Read register holds its value between loads; stores never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_memory.sv
// CPU data memory: stalls the CPU via BUSYWAIT for a fixed latency, then completes
// the latched load or store and signals completion with a single low DONE cycle.
module data_memory
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  count_reg;
    mem_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    logic valid_req;
    logic access_now;
    logic mem_we;
    logic mem_re;

    // Asserting READ and WRITE together is illegal and is simply ignored.
    assign valid_req  = READ ^ WRITE;
    assign access_now = (state_reg == ST_BUSY) && (count_reg == '0);
    assign mem_we     = access_now && (op_reg == MEM_STORE);
    assign mem_re     = access_now && (op_reg == MEM_LOAD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            op_reg    <= MEM_LOAD;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_req) begin
                        op_reg    <= WRITE ? MEM_STORE : MEM_LOAD;
                        addr_reg  <= ADDRESS;
                        data_reg  <= WRITEDATA;
                        count_reg <= CNT_W'(LATENCY - 1);
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (count_reg == '0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The IDLE term is combinational so the CPU stalls in the very cycle it asks.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            BUSYWAIT = (state_reg == ST_BUSY) || ((state_reg == ST_IDLE) && valid_req);
        end
    end

    dmem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk   (CLK),
        .rst   (RESET),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_reg),
        .wdata (data_reg),
        .rdata (READDATA)
    );

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory (LATENCY=5): expected stall lengths and load data
// are queued when a request is driven and compared when the access completes.
module tb_data_memory;

    localparam int LAT = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       READ = 1'b0;
    logic       WRITE = 1'b0;
    logic [7:0] ADDRESS = 8'h00;
    logic [7:0] WRITEDATA = 8'h00;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] model_mem [256];
    int         gap_q [$];
    int         busy_q [$];
    logic [7:0] rd_q [$];

    data_memory #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    endtask

    // Starts right after a falling edge. exp_gap = low cycles expected before the stall
    // (1 when issued during the previous access's DONE cycle). perturb changes the live
    // address/data in the middle of the BUSY phase.
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input int exp_gap, input bit perturb);
        int gap;
        int busy;
        READ = !wr;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        gap_q.push_back(exp_gap);
        busy_q.push_back(LAT + 1);
        if (!wr) rd_q.push_back(model_mem[a]);
        else model_mem[a] = d;
        #1;
        gap = 0;
        while (!BUSYWAIT && gap < 10) begin
            gap++;
            @(negedge CLK);
            #1;
        end
        busy = 0;
        while (BUSYWAIT && busy < 40) begin
            busy++;
            if (perturb && busy == 3) begin
                ADDRESS = a + 8'h01;
                WRITEDATA = ~d;
            end
            @(negedge CLK);
            #1;
        end
        check_val("gap", gap, gap_q.pop_front());
        check_val("busy", busy, busy_q.pop_front());
        if (!wr) check_val("rdata", READDATA, rd_q.pop_front());
        $display("txn %s addr=%02h wdata=%02h busy=%0d rdata=%02h",
                 wr ? "store" : "load ", a, d, busy, READDATA);
    endtask

    task automatic end_req();
        READ = 1'b0;
        WRITE = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        access(1'b1, a, d, 0, 1'b0);
        end_req();
    endtask

    task automatic do_load(input logic [7:0] a);
        access(1'b0, a, 8'h00, 0, 1'b0);
        end_req();
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        clear_model();
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    logic [7:0] held_rd;

    initial begin
        clear_model();
        RESET = 1'b1;
        #1;
        check_val("reset_busy", BUSYWAIT, 1'b0);
        check_val("reset_rdata", READDATA, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // 1: store then load
        do_store(8'h10, 8'hA5);
        do_load(8'h10);

        // 2: back-to-back stores, second issued during the DONE cycle
        access(1'b1, 8'h00, 8'h3C, 0, 1'b0);
        access(1'b1, 8'h01, 8'hC3, 1, 1'b0);
        end_req();
        do_load(8'h00);
        do_load(8'h01);

        // 3: illegal READ&WRITE held three cycles
        held_rd = READDATA;
        READ = 1'b1;
        WRITE = 1'b1;
        ADDRESS = 8'h20;
        WRITEDATA = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("illegal_busy", BUSYWAIT, 1'b0);
            @(negedge CLK);
        end
        check_val("illegal_rdata", READDATA, held_rd);
        end_req();
        do_load(8'h20);

        // 4: live inputs change while BUSY
        access(1'b1, 8'h30, 8'h11, 0, 1'b1);
        end_req();
        do_load(8'h31);
        do_load(8'h30);

        // 5: reset in the third BUSY cycle of a store
        WRITE = 1'b1;
        ADDRESS = 8'h05;
        WRITEDATA = 8'h77;
        repeat (3) @(negedge CLK);
        #1;
        check_val("midop_busy_before", BUSYWAIT, 1'b1);
        RESET = 1'b1;
        #1;
        check_val("midop_busy_after", BUSYWAIT, 1'b0);
        check_val("midop_rdata", READDATA, 8'h00);
        clear_model();
        WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        do_load(8'h05);

        // 6: top address is an ordinary location
        do_store(8'hFF, 8'h99);
        do_load(8'hFF);
        do_load(8'h00);

        // Reset also clears a location written earlier in this run
        pulse_reset();
        do_load(8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
